// File: rtl/rv32_dmem_pkg.sv
// Shared types and the store formatting helper for the dmem responder.
package rv32_dmem_pkg;

   // Store width encodings; 2'd3 is reserved and handled as a word store.
   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;

   // Word index is carried at full address width and zero-extended from the
   // RAM index, so aliased addresses compare equal after wrap.
   localparam int unsigned WIDX_W = 30;

   typedef struct packed {
      logic [WIDX_W-1:0] word_idx;
      logic [3:0]        be;
      logic [31:0]       data;
   } sb_entry_t;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
      logic        misalign;
   } st_fmt_t;

   // Lane-align a store. The 4-bit shift drops enables that fall beyond
   // lane 3, which is how misaligned stores get truncated.
   function automatic st_fmt_t fmt_store(input logic [1:0]  addr_lo,
                                         input logic [1:0]  width,
                                         input logic [31:0] data);
      st_fmt_t    f;
      logic [3:0] be_base;
      case (width)
         W_BYTE:  be_base = 4'b0001;
         W_HALF:  be_base = 4'b0011;
         default: be_base = 4'b1111;
      endcase
      f.be       = be_base << addr_lo;
      f.data     = data << {addr_lo, 3'b000};
      f.misalign = ((width == W_HALF) && addr_lo[0]) ||
                   (width[1] && (addr_lo != 2'b00));
      return f;
   endfunction

endpackage

// File: rtl/rv32_dmem_sb.sv
// In-order circular store buffer with a per-lane forwarding lookup.
// Handshake: push_i is only raised when an entry is free (or pop_i frees one
// in the same cycle); pop_i is only raised when count_o is non-zero.
module rv32_dmem_sb
   import rv32_dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     srst_n_i,
   input  logic                     push_i,
   input  sb_entry_t                push_entry_i,
   input  logic                     pop_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output sb_entry_t                head_o,
   input  logic [WIDX_W-1:0]        look_idx_i,
   output logic [3:0]               hit_o,
   output logic [31:0]              fwd_data_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sb_entry_t          entry_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [PTR_W-1:0]   pos;

   // Next-state for pointers and occupancy; power-of-two depth wraps freely.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   // Pointer/count registers; reset discards every pending entry.
   always_ff @(posedge clk) begin
      if (!srst_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: only slots covered by count are ever read.
   always_ff @(posedge clk) begin
      if (push_i) entry_q[wr_ptr_q] <= push_entry_i;
   end

   // Walk oldest to newest so a younger matching lane overwrites an older one.
   always_comb begin
      hit_o      = 4'b0000;
      fwd_data_o = 32'h0;
      pos        = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         pos = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (entry_q[pos].word_idx == look_idx_i)) begin
            for (int l = 0; l < 4; l++) begin
               if (entry_q[pos].be[l]) begin
                  hit_o[l]            = 1'b1;
                  fwd_data_o[l*8 +: 8] = entry_q[pos].data[l*8 +: 8];
               end
            end
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/rv32_dmem_resp.sv
// Data-memory responder: combinational loads from a word RAM with byte-wise
// forwarding from a small store buffer that drains only on load-free cycles.
module rv32_dmem_resp
   import rv32_dmem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned SB_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        c_srst_n,
   input  logic        c_dmem_load,
   input  logic [31:0] dmem_load_addr,
   output logic [31:0] dmem_load_data,
   input  logic        c_dmem_store,
   input  logic [31:0] dmem_store_addr,
   input  logic [1:0]  dmem_store_width,
   input  logic [31:0] dmem_store_data,
   output logic        c_dmem_stall,
   output logic        c_sb_empty,
   output logic        c_dmem_misalign
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

   logic [31:0]       ram [MEM_WORDS];
   st_fmt_t           st_fmt;
   sb_entry_t         st_entry;
   sb_entry_t         head;
   logic [CNT_W-1:0]  sb_count;
   logic              sb_full;
   logic              drain;
   logic              accept;
   logic [IDX_W-1:0]  load_idx;
   logic [IDX_W-1:0]  head_idx;
   logic [3:0]        fwd_hit;
   logic [31:0]       fwd_data;
   logic [31:0]       ram_word;
   logic              misalign_q, misalign_d;
   logic              unused_bits;

   assign st_fmt            = fmt_store(dmem_store_addr[1:0], dmem_store_width, dmem_store_data);
   assign st_entry.word_idx = WIDX_W'(dmem_store_addr[IDX_W+1:2]);
   assign st_entry.be       = st_fmt.be;
   assign st_entry.data     = st_fmt.data;

   // One RAM port: a load owns it, otherwise the oldest store drains.
   // Reset suppresses both so a mid-drain store never reaches RAM.
   assign sb_full      = (sb_count == CNT_W'(SB_DEPTH));
   assign drain        = c_srst_n & (sb_count != '0) & ~c_dmem_load;
   assign accept       = c_srst_n & c_dmem_store & (~sb_full | drain);
   assign c_dmem_stall = c_srst_n & c_dmem_store & sb_full & c_dmem_load;
   assign c_sb_empty   = ~c_srst_n | (sb_count == '0);

   rv32_dmem_sb #(
      .DEPTH (SB_DEPTH)
   ) u_sb (
      .clk          (clk),
      .srst_n_i     (c_srst_n),
      .push_i       (accept),
      .push_entry_i (st_entry),
      .pop_i        (drain),
      .count_o      (sb_count),
      .head_o       (head),
      .look_idx_i   (WIDX_W'(load_idx)),
      .hit_o        (fwd_hit),
      .fwd_data_o   (fwd_data)
   );

   assign head_idx = head.word_idx[IDX_W-1:0];
   assign load_idx = dmem_load_addr[IDX_W+1:2];
   assign ram_word = ram[load_idx];

   // Drain the head entry into RAM under its byte enables.
   always_ff @(posedge clk) begin
      if (drain) begin
         for (int l = 0; l < 4; l++) begin
            if (head.be[l]) ram[head_idx][l*8 +: 8] <= head.data[l*8 +: 8];
         end
      end
   end

   // Per-lane select between newest buffered byte and RAM.
   always_comb begin
      dmem_load_data = ram_word;
      for (int l = 0; l < 4; l++) begin
         if (fwd_hit[l]) dmem_load_data[l*8 +: 8] = fwd_data[l*8 +: 8];
      end
   end

   assign misalign_d = accept & st_fmt.misalign;

   // Misalign flag is a one-cycle pulse following the accepting edge.
   always_ff @(posedge clk) begin
      if (!c_srst_n) misalign_q <= 1'b0;
      else           misalign_q <= misalign_d;
   end

   assign c_dmem_misalign = misalign_q;

   assign unused_bits = ^{dmem_load_addr[31:IDX_W+2], dmem_load_addr[1:0],
                          dmem_store_addr[31:IDX_W+2], head.word_idx[WIDX_W-1:IDX_W]};

endmodule

// File: tb/tb_rv32_dmem_resp.sv
// Bench for rv32_dmem_resp: directed vector table, a reset-while-full
// sequence, then random traffic against a queue-based memory model.
module tb_rv32_dmem_resp;

   localparam int MEM_WORDS = 4096;
   localparam int SB_DEPTH  = 4;
   localparam logic [1:0] WB = 2'd0, WH = 2'd1, WW = 2'd2;

   logic        clk = 1'b0;
   logic        c_srst_n;
   logic        c_dmem_load;
   logic [31:0] dmem_load_addr;
   logic [31:0] dmem_load_data;
   logic        c_dmem_store;
   logic [31:0] dmem_store_addr;
   logic [1:0]  dmem_store_width;
   logic [31:0] dmem_store_data;
   logic        c_dmem_stall;
   logic        c_sb_empty;
   logic        c_dmem_misalign;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   rv32_dmem_resp #(
      .MEM_WORDS (MEM_WORDS),
      .SB_DEPTH  (SB_DEPTH)
   ) dut (
      .clk              (clk),
      .c_srst_n         (c_srst_n),
      .c_dmem_load      (c_dmem_load),
      .dmem_load_addr   (dmem_load_addr),
      .dmem_load_data   (dmem_load_data),
      .c_dmem_store     (c_dmem_store),
      .dmem_store_addr  (dmem_store_addr),
      .dmem_store_width (dmem_store_width),
      .dmem_store_data  (dmem_store_data),
      .c_dmem_stall     (c_dmem_stall),
      .c_sb_empty       (c_sb_empty),
      .c_dmem_misalign  (c_dmem_misalign)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Architectural view: a byte-addressed word memory plus an ordered list of
   // stores not yet written to it.
   typedef struct {
      int          idx;
      logic [3:0]  be;
      logic [31:0] data;
   } pend_t;

   pend_t       exp_q[$];
   logic [31:0] mdl_mem [int];
   bit          mdl_mis = 1'b0;

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % MEM_WORDS);
   endfunction

   function automatic int size_of(input logic [1:0] w);
      return (w == WB) ? 1 : (w == WH) ? 2 : 4;
   endfunction

   function automatic pend_t mk_pend(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      pend_t p;
      int    lane;
      p.idx  = widx(a);
      p.be   = 4'b0000;
      p.data = 32'h0;
      for (int b = 0; b < size_of(w); b++) begin
         lane = int'(a % 4) + b;
         if (lane < 4) begin
            p.be[lane]           = 1'b1;
            p.data[8*lane +: 8] = d[8*b +: 8];
         end
      end
      return p;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input pend_t p);
      logic [31:0] r = w;
      for (int l = 0; l < 4; l++) if (p.be[l]) r[8*l +: 8] = p.data[8*l +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] a);
      logic [31:0] w;
      int          idx = widx(a);
      w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'hxxxxxxxx;
      foreach (exp_q[i]) if (exp_q[i].idx == idx) w = merge(w, exp_q[i]);
      return w;
   endfunction

   task automatic mdl_step(input bit rst_n, input bit ld, input bit st,
                           input logic [31:0] sa, input logic [1:0] sw, input logic [31:0] sd);
      bit    drn, acc;
      pend_t h;
      if (!rst_n) begin
         exp_q.delete();
         mdl_mis = 1'b0;
      end else begin
         drn = (exp_q.size() > 0) && !ld;
         acc = st && ((exp_q.size() < SB_DEPTH) || drn);
         if (drn) begin
            h = exp_q.pop_front();
            mdl_mem[h.idx] = merge(mdl_mem.exists(h.idx) ? mdl_mem[h.idx] : 32'hxxxxxxxx, h);
         end
         if (acc) exp_q.push_back(mk_pend(sa, sw, sd));
         mdl_mis = acc && ((int'(sa % 4) % size_of(sw)) != 0);
      end
   endtask

   // ---------------- driver ----------------
   typedef struct {
      bit          rst_n;
      bit          ld;
      logic [31:0] la;
      bit          st;
      logic [31:0] sa;
      logic [1:0]  sw;
      logic [31:0] sd;
      bit          chk_d;
      logic [31:0] exp_d;
      bit          exp_stall;
      bit          exp_empty;
      bit          exp_mis;
   } vec_t;

   // Called at posedge+1; outputs sampled on the falling edge.
   task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
      logic [31:0] e_d;
      bit          e_stall, e_empty, e_mis, e_chk;
      c_srst_n         = v.rst_n;
      c_dmem_load      = v.ld;
      dmem_load_addr   = v.la;
      c_dmem_store     = v.st;
      dmem_store_addr  = v.sa;
      dmem_store_width = v.sw;
      dmem_store_data  = v.sd;
      @(negedge clk);
      if (use_tbl) begin
         e_d = v.exp_d; e_stall = v.exp_stall; e_empty = v.exp_empty;
         e_mis = v.exp_mis; e_chk = v.chk_d;
      end else begin
         e_d     = mdl_load(v.la);
         e_stall = v.rst_n && v.st && v.ld && (exp_q.size() == SB_DEPTH);
         e_empty = !v.rst_n || (exp_q.size() == 0);
         e_mis   = mdl_mis;
         e_chk   = v.ld && ((^e_d) !== 1'bx);
      end
      check({tag, " stall"}, 32'(c_dmem_stall), 32'(e_stall));
      check({tag, " empty"}, 32'(c_sb_empty), 32'(e_empty));
      check({tag, " misalign"}, 32'(c_dmem_misalign), 32'(e_mis));
      if (e_chk) check({tag, " data"}, dmem_load_data, e_d);
      mdl_step(v.rst_n, v.ld, v.st, v.sa, v.sw, v.sd);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input bit rst_n, input bit ld, input logic [31:0] la,
                               input bit st, input logic [31:0] sa, input logic [1:0] sw,
                               input logic [31:0] sd, input bit chk, input logic [31:0] ed,
                               input bit es, input bit ee, input bit em);
      vec_t v;
      v.rst_n = rst_n; v.ld = ld; v.la = la; v.st = st; v.sa = sa; v.sw = sw; v.sd = sd;
      v.chk_d = chk; v.exp_d = ed; v.exp_stall = es; v.exp_empty = ee; v.exp_mis = em;
      return v;
   endfunction

   function automatic vec_t idle(input bit ee);
      return mk(1, 0, 0, 0, 0, WW, 0, 0, 0, 0, ee, 0);
   endfunction

   function automatic vec_t ldv(input logic [31:0] la, input logic [31:0] ed, input bit ee);
      return mk(1, 1, la, 0, 0, WW, 0, 1, ed, 0, ee, 0);
   endfunction

   vec_t tbl[$];
   vec_t v;

   initial begin
      c_srst_n = 1'b0; c_dmem_load = 1'b0; dmem_load_addr = '0;
      c_dmem_store = 1'b0; dmem_store_addr = '0; dmem_store_width = WW; dmem_store_data = '0;
      repeat (3) @(posedge clk);
      #1;

      // ---- directed table ----
      tbl.push_back(mk(0, 0, 0, 0, 0, WW, 0, 0, 0, 0, 1, 0));                            // reset
      tbl.push_back(mk(1, 0, 0, 1, 32'h100, WW, 32'hDEADBEEF, 0, 0, 0, 1, 0));
      tbl.push_back(ldv(32'h100, 32'hDEADBEEF, 0));                                       // forwarded
      tbl.push_back(idle(0));                                                             // drains
      tbl.push_back(ldv(32'h100, 32'hDEADBEEF, 1));                                       // from RAM
      tbl.push_back(mk(1, 1, 32'h100, 1, 32'h200, WW, 32'h11223344, 1, 32'hDEADBEEF, 0, 1, 0));
      tbl.push_back(mk(1, 1, 32'h100, 1, 32'h201, WB, 32'h000000AA, 1, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h200, 1, 32'h202, WH, 32'h0000BBCC, 1, 32'h1122AA44, 0, 0, 0));
      tbl.push_back(ldv(32'h200, 32'hBBCCAA44, 0));
      tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(0));
      tbl.push_back(ldv(32'h200, 32'hBBCCAA44, 1));
      tbl.push_back(mk(1, 1, 32'h100, 1, 32'h400, WW, 32'hA0000001, 1, 32'hDEADBEEF, 0, 1, 0));
      tbl.push_back(mk(1, 1, 32'h400, 1, 32'h404, WW, 32'hA0000002, 1, 32'hA0000001, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h404, 1, 32'h408, WW, 32'hA0000003, 1, 32'hA0000002, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h408, 1, 32'h40C, WW, 32'hA0000004, 1, 32'hA0000003, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h40C, 1, 32'h410, WW, 32'hA0000005, 1, 32'hA0000004, 1, 0, 0)); // full+load
      tbl.push_back(mk(1, 0, 0, 1, 32'h410, WW, 32'hA0000005, 0, 0, 0, 0, 0));             // drain+accept
      tbl.push_back(ldv(32'h410, 32'hA0000005, 0));
      tbl.push_back(mk(1, 1, 32'h400, 1, 32'h404, WB, 32'h00000077, 1, 32'hA0000001, 1, 0, 0));
      tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(0));
      tbl.push_back(ldv(32'h40C, 32'hA0000004, 1));
      tbl.push_back(mk(1, 0, 0, 1, 32'h300, WW, 32'h12345678, 0, 0, 0, 1, 0));
      tbl.push_back(idle(0));
      tbl.push_back(mk(1, 1, 32'h300, 1, 32'h303, WW, 32'hCAFEF00D, 1, 32'h12345678, 0, 1, 0));
      tbl.push_back(mk(1, 1, 32'h300, 0, 0, WW, 0, 1, 32'h0D345678, 0, 0, 1));           // pulse
      tbl.push_back(ldv(32'h300, 32'h0D345678, 0));                                       // pulse gone
      tbl.push_back(idle(0));
      tbl.push_back(ldv(32'h300, 32'h0D345678, 1));
      tbl.push_back(mk(1, 0, 0, 1, 32'h0, WW, 32'h99887766, 0, 0, 0, 1, 0));
      tbl.push_back(idle(0));
      tbl.push_back(mk(1, 0, 0, 1, 32'h4000, WB, 32'h00000055, 0, 0, 0, 1, 0));           // wraps to word 0
      tbl.push_back(ldv(32'h0, 32'h99887755, 0));
      tbl.push_back(idle(0));
      tbl.push_back(ldv(32'h0, 32'h99887755, 1));
      tbl.push_back(mk(1, 1, 32'h200, 1, 32'h100, WW, 32'hF0F0F0F0, 1, 32'hBBCCAA44, 0, 1, 0));
      tbl.push_back(mk(1, 1, 32'h300, 1, 32'h200, WW, 32'hF1F1F1F1, 1, 32'h0D345678, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h100, 1, 32'h300, WW, 32'hF2F2F2F2, 1, 32'hF0F0F0F0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h100, 0, 0, WW, 0, 0, 0, 0, 1, 0));                       // reset mid-op
      tbl.push_back(ldv(32'h100, 32'hDEADBEEF, 1));
      tbl.push_back(ldv(32'h200, 32'hBBCCAA44, 1));
      tbl.push_back(ldv(32'h300, 32'h0D345678, 1));

      foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // ---- hand-written: reset while full with a competing store+load ----
      for (int i = 0; i < SB_DEPTH; i++)
         run_cycle(mk(1, 1, 32'h100, 1, 32'h500 + 32'(4*i), WH, 32'h1111 * (i + 1), 0, 0, 0, 0, 0),
                   1'b0, $sformatf("fill%0d", i));
      run_cycle(mk(1, 1, 32'h500, 1, 32'h510, WW, 32'h5A5A5A5A, 0, 0, 0, 0, 0), 1'b0, "full_stall");
      run_cycle(mk(0, 1, 32'h500, 1, 32'h510, WW, 32'h5A5A5A5A, 0, 0, 0, 0, 0), 1'b0, "rst_full");
      run_cycle(mk(1, 1, 32'h100, 0, 0, WW, 0, 0, 0, 0, 0, 0), 1'b0, "post_rst");

      // ---- random traffic against the model ----
      for (int w = 0; w < 16; w++)
         run_cycle(mk(1, 0, 0, 1, 32'h800 + 32'(4*w), WW, $urandom, 0, 0, 0, 0, 0), 1'b0, "rinit");
      run_cycle(idle(0), 1'b0, "rinit_idle");
      run_cycle(idle(0), 1'b0, "rinit_idle");
      for (int n = 0; n < 800; n++) begin
         v       = idle(0);
         v.rst_n = ($urandom_range(0, 63) != 0);
         v.ld    = ($urandom_range(0, 2) != 0);
         v.la    = 32'h800 + 32'($urandom_range(0, 63)) + (($urandom_range(0, 7) == 0) ? 32'h4000 : 32'h0);
         v.st    = ($urandom_range(0, 1) != 0);
         v.sa    = 32'h800 + 32'($urandom_range(0, 63)) + (($urandom_range(0, 7) == 0) ? 32'h4000 : 32'h0);
         v.sw    = 2'($urandom_range(0, 3));
         v.sd    = $urandom;
         run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rv32_dmem_resp.md
Name: rv32_dmem_resp

Overview:
Data-memory responder for the single-port RV32IMC core. It is the far end of the core's dmem load/store interface.
- Services loads combinationally from a single-port word RAM.
- Accepts stores into a small in-order store buffer. The buffer drains to RAM only in cycles without a load, which models one RAM access per cycle.
- Loads forward byte-wise from pending buffered stores.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words; power of two; index = addr[2+log2(MEM_WORDS)-1:2], upper bits ignored (wrap).
- SB_DEPTH, 4, store-buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge
- c_srst_n  in  1  synchronous active-low reset
- c_dmem_load  in  1  load request this cycle
- dmem_load_addr  in  32  load byte address
- dmem_load_data  out  32  aligned word containing dmem_load_addr (combinational); core extracts and extends
- c_dmem_store  in  1  store request this cycle
- dmem_store_addr  in  32  store byte address
- dmem_store_width  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- dmem_store_data  in  32  store data, LSB-justified
- c_dmem_stall  out  1  store not accepted this cycle; core holds the store
- c_sb_empty  out  1  store buffer empty (fence support)
- c_dmem_misalign  out  1  registered one-cycle pulse: previous accepted store was misaligned

Behaviour:
- Reset (clk edge with c_srst_n=0):
  - rd/wr pointers and count cleared; pending stores discarded, including mid-drain.
  - c_dmem_misalign=0. During and after reset: c_sb_empty=1, c_dmem_stall=0.
  - RAM contents are not reset.
- Store formatting:
  - Byte enables: byte=4'b0001, half=4'b0011, word=4'b1111, each shifted left by addr[1:0]. Lanes above bit 3 are dropped.
  - Data shifted left by 8*addr[1:0].
  - Entry = {word index, be[3:0], data[31:0]}.
- Misalign:
  - Condition: half with addr[0]=1, or word with addr[1:0]!=0.
  - The store is still accepted with truncated lanes, and c_dmem_misalign=1 in the following cycle only.
- Store accept:
  - At a clk edge when c_dmem_store=1 and (count<SB_DEPTH or a drain occurs this cycle); the entry is written at wr_ptr.
  - c_dmem_stall = c_dmem_store & (count==SB_DEPTH) & c_dmem_load. Full with no load: drain and accept in the same cycle, count unchanged.
- Drain:
  - Occurs when count>0 and c_dmem_load=0.
  - The oldest entry is written to RAM under its byte enables and rd_ptr advances.
  - Exactly one drain per cycle maximum.
- Load data (combinational, zero latency):
  - Per byte lane, the newest buffered entry with matching word index and that lane's enable supplies the byte; otherwise RAM.
  - An entry draining this cycle cannot coexist with a load (drain is blocked by loads), so no hazard arises.
  - A store presented in the same cycle as a load is not visible to that load.
  - When c_dmem_load=0, dmem_load_data is don't-care but must be X-free after RAM initialisation.
- Count/pointers:
  - count = count + accept - drain; it never exceeds SB_DEPTH or underflows.
  - Pointers wrap modulo SB_DEPTH.
- c_sb_empty = (count==0), combinational from registered count.
- Same-address consecutive stores: both are buffered in order; forwarding picks the newer lane-wise. Partial overlap merges per byte.

Decomposition:
- Package rv32_dmem_pkg:
  - width encodings (W_BYTE, W_HALF, W_WORD)
  - typedef sb_entry_t {word_idx, be, data}
  - function fmt_store(addr, width, data) -> {be, shifted data, misalign}
- Sub-module rv32_dmem_sb:
  - circular store buffer with count and push/pop
  - parallel per-lane forwarding lookup returning {hit[3:0], byte data}, newest-wins priority
- Top: RAM array, drain/accept control, lane mux.

Test Plan:
- Word store then load: store word 0xDEADBEEF @0x100, next cycle load @0x100 -> data 0xDEADBEEF, forwarded while c_sb_empty=0. Idle 1 cycle -> drained, c_sb_empty=1, reload still returns 0xDEADBEEF from RAM.
- Byte/half merge: word 0x11223344 @0x200, byte 0xAA @0x201, half 0xBBCC @0x202, then load @0x200 -> 0xBBCCAA44, identical before and after drain.
- Full buffer: 4 stores during continuous loads -> count=4. 5th store with a concurrent load -> c_dmem_stall=1. 5th store with no load -> stall=0, one drain plus accept, count stays 4.
- Misaligned: word 0xCAFEF00D @0x303 -> only byte lane 3 written with 0x0D; c_dmem_misalign high exactly one cycle later. Load @0x300 -> 0x0D______ (lane 3 only changed).
- Reset mid-operation: 3 stores buffered under continuous loads, assert c_srst_n=0 for one edge -> c_sb_empty=1, c_dmem_stall=0, c_dmem_misalign=0. Loads of those addresses return prior RAM contents.
- Wrap: MEM_WORDS=4096, store 0x55 byte @0x4000 -> load @0x0000 returns byte lane 0 = 0x55.
